// File: rtl/trap_pkg.sv
// Shared types and constants for the M-mode trap sequencer.
// States, CSR addresses, cause codes and mstatus bit positions.
package trap_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_W_EPC,
    S_W_CAUSE,
    S_W_TVAL,
    S_W_STAT,
    S_R_STAT,
    S_REDIR
  } trap_state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Exception codes; the interrupt flag (MSB) is added by the user.
  localparam int unsigned CAUSE_ILLEGAL   = 2;
  localparam int unsigned CAUSE_ECALL_M   = 11;
  localparam int unsigned CAUSE_M_EXT_IRQ = 11;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LSB  = 11;

endpackage

// File: rtl/trap_sequencer.sv
// M-mode trap entry / mret controller beside the ID stage.
// Drains the pipe, writes CSRs serially, then redirects the PC.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            illegal_ins,
  input  logic            ecall,
  input  logic            trap_ret,
  input  logic            irq_ext,
  input  logic [XLEN-1:0] pc_id,
  input  logic [XLEN-1:0] ins_id,
  input  logic [XLEN-1:0] mstatus_q,
  input  logic [XLEN-1:0] mtvec_q,
  input  logic [XLEN-1:0] mepc_q,
  output logic            busy,
  output logic            flush,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

  trap_state_t     r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_cause;
  logic            r_ret;

  logic            w_ill;
  logic            w_ecall;
  logic            w_ret;
  logic            w_irq;
  logic            w_take;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_stat_trap;
  logic [XLEN-1:0] w_stat_ret;

  // Fixed priority: illegal > ecall > mret > enabled interrupt
  assign w_ill   = illegal_ins;
  assign w_ecall = ecall & ~illegal_ins;
  assign w_ret   = trap_ret & ~illegal_ins & ~ecall;
  assign w_irq   = irq_ext & mstatus_q[MIE_BIT]
                 & ~illegal_ins & ~ecall & ~trap_ret;
  assign w_take  = w_ill | w_ecall | w_ret | w_irq;

  always_comb begin
    w_cause = '0;
    unique case (1'b1)
      w_ill:   w_cause = XLEN'(CAUSE_ILLEGAL);
      w_ecall: w_cause = XLEN'(CAUSE_ECALL_M);
      w_irq:   w_cause = {1'b1, (XLEN-1)'(CAUSE_M_EXT_IRQ)};
      default: w_cause = '0;
    endcase
  end

  always_comb begin
    w_stat_trap = mstatus_q;
    w_stat_trap[MPIE_BIT] = mstatus_q[MIE_BIT];
    w_stat_trap[MIE_BIT] = 1'b0;
    w_stat_trap[MPP_LSB+1:MPP_LSB] = 2'b11;
    w_stat_ret = mstatus_q;
    w_stat_ret[MIE_BIT] = mstatus_q[MPIE_BIT];
    w_stat_ret[MPIE_BIT] = 1'b1;
    w_stat_ret[MPP_LSB+1:MPP_LSB] = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_tval  <= '0;
      r_cause <= '0;
      r_ret   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_take) begin
            r_pc    <= pc_id;
            r_tval  <= w_ill ? ins_id : '0;
            r_cause <= w_cause;
            r_ret   <= w_ret;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= r_ret ? S_R_STAT : S_W_EPC;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_W_EPC:   r_state <= S_W_CAUSE;
        S_W_CAUSE: r_state <= S_W_TVAL;
        S_W_TVAL:  r_state <= S_W_STAT;
        S_W_STAT:  r_state <= S_REDIR;
        S_R_STAT:  r_state <= S_REDIR;
        S_REDIR:   r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign flush = (r_state != S_IDLE);

  always_comb begin
    csr_we      = 1'b0;
    csr_waddr   = '0;
    csr_wdata   = '0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    unique case (r_state)
      S_W_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = r_pc;
      end
      S_W_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = r_cause;
      end
      S_W_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = r_tval;
      end
      S_W_STAT: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = w_stat_trap;
      end
      S_R_STAT: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = w_stat_ret;
      end
      S_REDIR: begin
        pc_redirect = 1'b1;
        pc_target   = r_ret ? mepc_q : (mtvec_q & ~XLEN'(3));
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: directed cases plus random traffic.
// A transaction model predicts each CSR write and redirect with its cycle.
module tb_trap_sequencer;

  localparam int XLEN = 32;
  localparam int D    = 2;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic        illegal_ins = 1'b0;
  logic        ecall = 1'b0;
  logic        trap_ret = 1'b0;
  logic        irq_ext = 1'b0;
  logic [31:0] pc_id = '0;
  logic [31:0] ins_id = '0;
  logic [31:0] mstatus_q = '0;
  logic [31:0] mtvec_q = '0;
  logic [31:0] mepc_q = '0;
  logic        busy;
  logic        flush;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        pc_redirect;
  logic [31:0] pc_target;

  trap_sequencer #(.XLEN(XLEN), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .Rst(Rst),
    .illegal_ins(illegal_ins), .ecall(ecall),
    .trap_ret(trap_ret), .irq_ext(irq_ext),
    .pc_id(pc_id), .ins_id(ins_id),
    .mstatus_q(mstatus_q), .mtvec_q(mtvec_q), .mepc_q(mepc_q),
    .busy(busy), .flush(flush),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .pc_redirect(pc_redirect), .pc_target(pc_target)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          redir;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   busy_start = 0;
  int   busy_until = -1;
  int   checks = 0;
  int   errors = 0;
  int   n_we = 0;
  int   n_redir = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] trap_stat(input logic [31:0] m);
    logic [31:0] r;
    r = (m & ~32'h0000_1888) | 32'h0000_1800;
    if (m[3]) r = r | 32'h0000_0080;
    return r;
  endfunction

  function automatic logic [31:0] ret_stat(input logic [31:0] m);
    logic [31:0] r;
    r = (m & ~32'h0000_1888) | 32'h0000_1880;
    if (m[7]) r = r | 32'h0000_0008;
    return r;
  endfunction

  task automatic push(input int c, input bit rd,
                      input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.redir = rd; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  // Inputs driven now are sampled at the end of cycle k.
  task automatic model(input int k);
    logic [31:0] cause;
    logic [31:0] tval;
    if (!Rst) begin
      while (q.size() > 0 && q[q.size()-1].cyc > k) q.delete(q.size()-1);
      if (busy_until > k) busy_until = k;
      return;
    end
    if (k <= busy_until) return;
    if (!(illegal_ins || ecall || trap_ret || (irq_ext && mstatus_q[3])))
      return;
    busy_start = k + 1;
    if (!illegal_ins && !ecall && trap_ret) begin
      push(k + D + 1, 1'b0, 12'h300, ret_stat(mstatus_q));
      push(k + D + 2, 1'b1, 12'h000, mepc_q);
      busy_until = k + D + 2;
    end else begin
      cause = illegal_ins ? 32'd2 : (ecall ? 32'd11 : 32'h8000_000B);
      tval  = illegal_ins ? ins_id : 32'd0;
      push(k + D + 1, 1'b0, 12'h341, pc_id);
      push(k + D + 2, 1'b0, 12'h342, cause);
      push(k + D + 3, 1'b0, 12'h343, tval);
      push(k + D + 4, 1'b0, 12'h300, trap_stat(mstatus_q));
      push(k + D + 5, 1'b1, 12'h000, {mtvec_q[31:2], 2'b00});
      busy_until = k + D + 5;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rst, input bit ill, input bit ec,
                       input bit ret, input bit irq);
    Rst = rst; illegal_ins = ill; ecall = ec;
    trap_ret = ret; irq_ext = irq;
    model(cyc);
  endtask

  task automatic step(input bit rst, input bit ill, input bit ec,
                      input bit ret, input bit irq);
    tick();
    drive(rst, ill, ec, ret, irq);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin : mon
    bit   eb;
    exp_t e;
    if (mon_en) begin
      eb = (cyc >= busy_start) && (cyc <= busy_until);
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("flush", {31'd0, flush}, {31'd0, eb});
      if (!csr_we) begin
        chk("idle_waddr", {20'd0, csr_waddr}, 32'd0);
        chk("idle_wdata", csr_wdata, 32'd0);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_output: expected cycle %0d redir %0d addr %h data %h, not observed",
                 q[0].cyc, q[0].redir, q[0].addr, q[0].data);
        void'(q.pop_front());
      end
      if (csr_we) n_we++;
      if (pc_redirect) n_redir++;
      if (csr_we || pc_redirect) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: we %0d addr %h data %h redir %0d target %h, none expected (cycle %0d)",
                   csr_we, csr_waddr, csr_wdata, pc_redirect, pc_target, cyc);
        end else begin
          e = q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("is_redirect", {31'd0, pc_redirect}, {31'd0, e.redir});
          chk("csr_we", {31'd0, csr_we}, {31'd0, !e.redir});
          if (e.redir) begin
            chk("pc_target", pc_target, e.data);
          end else begin
            chk("csr_waddr", {20'd0, csr_waddr}, {20'd0, e.addr});
            chk("csr_wdata", csr_wdata, e.data);
          end
        end
      end
    end
  end

  initial begin : stim
    int nwe0;
    int nrd0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_we", {31'd0, csr_we}, 32'd0);
    chk("reset_redir", {31'd0, pc_redirect}, 32'd0);
    idle(2);

    // illegal instruction trap
    tick();
    mstatus_q = 32'h8; mtvec_q = 32'h201;
    pc_id = 32'h100; ins_id = 32'hFFFF_FFFF;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);

    // mret
    tick();
    mstatus_q = 32'h80; mepc_q = 32'h104;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(6);

    // masked interrupt, then enabled
    tick();
    mstatus_q = 32'h0; pc_id = 32'h2000;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    mstatus_q = 32'h8;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(9);

    // illegal and mret together
    tick();
    pc_id = 32'h140; ins_id = 32'h3020_0073;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(9);

    // ecall, reset during W_CAUSE
    tick();
    pc_id = 32'h300;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_we", {31'd0, csr_we}, 32'd0);
    chk("rst_mid_redir", {31'd0, pc_redirect}, 32'd0);
    idle(8);

    // second illegal pulse during drain
    nwe0 = n_we;
    nrd0 = n_redir;
    tick();
    pc_id = 32'h400; ins_id = 32'h0000_0000;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(8);
    chk("t6_we_pulses", n_we - nwe0, 32'd4);
    chk("t6_redirects", n_redir - nrd0, 32'd1);

    repeat (600) begin
      tick();
      if (cyc > busy_until) begin
        mstatus_q = $urandom;
        mtvec_q   = $urandom;
        mepc_q    = $urandom;
      end
      pc_id  = $urandom;
      ins_id = $urandom;
      drive($urandom_range(0, 63) != 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0);
    end

    idle(12);
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
